sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Round-robin arbiter that shares one sram_top instance (64-bit data, 8-bit byte mask, 14-bit address) between NR requesters in the accelerator.
- Typical requesters: weight loader, activation writer and output reader.
- Grants at most one access per cycle and drives the SRAM control and address pins.
- Returns read data to the requester that issued the read, after a fixed latency.

Parameters:
- NR, 3, number of requesters (2..4).
- DW, 64, data width.
- MW, 8, byte-mask width (DW/8).
- AW, 14, address width.
- RL, 1, SRAM read latency in cycles from the accepted read to valid dout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NR  per-requester request valid.
- req_ready  out  NR  per-requester grant; at most one bit high (one-hot or zero).
- req_we  in  NR  1 = write, 0 = read; one bit per requester.
- req_wem  in  NR*MW  byte write mask; requester i occupies bits [i*MW +: MW].
- req_addr  in  NR*AW  word address; requester i occupies bits [i*AW +: AW].
- req_wdata  in  NR*DW  write data; requester i occupies bits [i*DW +: DW].
- rsp_valid  out  NR  read-data valid, one-hot.
- rsp_rdata  out  DW  read data, shared bus; meaningful only where rsp_valid is high.
- sram_cs  out  1  to sram_top cs.
- sram_we  out  1  to sram_top we.
- sram_wem  out  MW  to sram_top wem.
- sram_addr  out  AW  to sram_top addr.
- sram_din  out  DW  to sram_top din.
- sram_dout  in  DW  from sram_top dout.

Behaviour:
- Clock is clk; reset rst is synchronous and active-high.
- Reset values:
  - Round-robin pointer rr_ptr = 0.
  - Response pipeline cleared, so rsp_valid = 0 in the cycle after rst is sampled high.
  - While rst is high: req_ready = 0, sram_cs = 0, sram_we = 0.
- Arbitration is combinational each cycle:
  - Scan requesters starting at index rr_ptr, wrapping modulo NR.
  - The first i with req_valid[i] = 1 is granted: req_ready[i] = 1.
  - The transfer completes in that cycle (valid && ready).
- SRAM pins:
  - When a grant exists: sram_cs = 1, and sram_we, sram_wem, sram_addr, sram_din are muxed from the granted requester.
  - When no request is valid: sram_cs = 0, sram_we = 0, and address/data hold the last granted values (no toggling).
- Pointer update:
  - On a grant to i, rr_ptr becomes (i+1) mod NR at the next edge.
  - With no grant, rr_ptr holds.
- Fairness: a continuously requesting requester waits at most NR-1 cycles.
- Read response:
  - An accepted read pushes {valid, one-hot id} into an RL-deep shift pipe.
  - After exactly RL cycles, rsp_valid[id] = 1 for one cycle and rsp_rdata = sram_dout.
  - Writes push an invalid entry and produce no response.
- Back-to-back reads from different requesters return in grant order, one per cycle, with no bubbles.
- Requesters may change request fields only after a handshake; the arbiter does not buffer requests.
- req_ready does not depend on rsp_valid; there is no response backpressure (requesters must always accept).
- Reset mid-operation: in-flight reads are dropped (pipe cleared) and no rsp_valid is issued for them. The SRAM performs no write while rst is high.
- NR = 1 degenerates to a pass-through: ready = valid, rr_ptr stays 0.

Optional Feature:
- Macro: SRAM_ARB_OUT_REG_EN.
- When defined:
  - rsp_rdata and rsp_valid are registered one extra stage; effective read latency is RL+1.
  - The pipe depth grows by 1, and reset also clears the added register.
- When undefined: rsp_rdata is driven combinationally from sram_dout, with latency RL as above.

Decomposition:
- Shared package sram_arb_pkg holds:
  - Constants for DW, MW, AW.
  - RD_LAT.
  - Requester id widths.
  - A request struct typedef {we, wem, addr, wdata}.
- One sub-module, rr_arbiter:
  - Parameterised NR.
  - Inputs: valid vector and rr_ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- Pointer register, muxes and response pipe stay in sram_arbiter.

Test Plan:
1. After reset, all req_valid = 0 → req_ready = 0, sram_cs = 0, rsp_valid = 0 for 10 cycles; rr_ptr = 0.
2. Requester 1 writes addr 0x0010, data 0x1122334455667788, wem 0xFF. Requester 1 then reads 0x0010 → rsp_valid = 3'b010 exactly RL cycles after the read handshake, with rsp_rdata = 0x1122334455667788.
3. All three requesters hold req_valid = 1 for 9 cycles → grant sequence 0,1,2,0,1,2,0,1,2; each req_ready is one-hot.
4. Partial write to addr 0x0020: wem 0x0F, data 0xAAAAAAAA_BBBBBBBB over a prior 0x0 word → a later read returns 0x00000000_BBBBBBBB.
5. Reads in consecutive cycles:
   - req0 reads addr 0x1 holding value 0x1; next cycle req2 reads addr 0x2 holding value 0x2.
   - Expect rsp_valid = 001 then 100 on consecutive cycles, with matching data.
   - Repeat with SRAM_ARB_OUT_REG_EN defined and check latency RL+1.
6. Read accepted, then rst asserted the next cycle for 2 cycles → no rsp_valid for that read; rr_ptr = 0 after reset.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_DW = 64;
  localparam int unsigned SRAM_MW = SRAM_DW / 8;
  localparam int unsigned SRAM_AW = 14;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MAX_NR  = 4;
  localparam int unsigned ID_W    = 2;

  // Width of an encoded requester index; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic               we;
    logic [SRAM_MW-1:0] wem;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NR = 3,
  parameter int unsigned IW = id_width(NR)
) (
  input  logic [NR-1:0] valid,
  input  logic [IW-1:0] ptr,
  output logic [NR-1:0] grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      j = (32'(ptr) + k) % NR;
      if (!any && valid[j]) begin
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM among NR requesters, with read-response routing.
// Optional macro SRAM_ARB_OUT_REG_EN adds an output register stage on rsp_valid/rsp_rdata.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NR = 3,
  parameter int unsigned DW = SRAM_DW,
  parameter int unsigned MW = SRAM_MW,
  parameter int unsigned AW = SRAM_AW,
  parameter int unsigned RL = RD_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    req_valid,
  output logic [NR-1:0]    req_ready,
  input  logic [NR-1:0]    req_we,
  input  logic [NR*MW-1:0] req_wem,
  input  logic [NR*AW-1:0] req_addr,
  input  logic [NR*DW-1:0] req_wdata,
  output logic [NR-1:0]    rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             sram_cs,
  output logic             sram_we,
  output logic [MW-1:0]    sram_wem,
  output logic [AW-1:0]    sram_addr,
  output logic [DW-1:0]    sram_din,
  input  logic [DW-1:0]    sram_dout
);

  localparam int unsigned IW = id_width(NR);

  logic [IW-1:0] rr_ptr;
  logic [NR-1:0] grant_raw;
  logic [IW-1:0] gidx;
  logic          any_raw;
  logic          granted;
  logic          rd_acc;

  logic [MW-1:0] hold_wem;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_din;

  // Each entry is {valid, one-hot requester id}; pipe[RL-1] lines up with sram_dout.
  logic [NR:0]   pipe [RL];
  logic [NR:0]   tail;
  logic [NR-1:0] tail_valid;

  rr_arbiter #(.NR(NR), .IW(IW)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant_raw),
    .idx   (gidx),
    .any   (any_raw)
  );

  assign req_ready = rst ? '0 : grant_raw;
  assign granted   = any_raw & ~rst;

  always_comb begin
    sram_cs   = granted;
    sram_we   = 1'b0;
    sram_wem  = hold_wem;
    sram_addr = hold_addr;
    sram_din  = hold_din;
    for (int unsigned i = 0; i < NR; i++) begin
      if (req_ready[i]) begin
        sram_we   = req_we[i];
        sram_wem  = req_wem[i*MW +: MW];
        sram_addr = req_addr[i*AW +: AW];
        sram_din  = req_wdata[i*DW +: DW];
      end
    end
  end

  assign rd_acc = granted & ~sram_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      hold_wem  <= '0;
      hold_addr <= '0;
      hold_din  <= '0;
    end else if (granted) begin
      rr_ptr    <= (gidx == IW'(NR - 1)) ? '0 : gidx + IW'(1);
      hold_wem  <= sram_wem;
      hold_addr <= sram_addr;
      hold_din  <= sram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < RL; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= {rd_acc, req_ready};
      for (int unsigned k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign tail       = pipe[RL-1];
  assign tail_valid = tail[NR] ? tail[NR-1:0] : '0;

`ifdef SRAM_ARB_OUT_REG_EN
  logic [NR-1:0] out_valid;
  logic [DW-1:0] out_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_rdata <= '0;
    end else begin
      out_valid <= tail_valid;
      out_rdata <= sram_dout;
    end
  end

  assign rsp_valid = out_valid;
  assign rsp_rdata = out_rdata;
`else
  // Gating with rst drops a read whose data would surface in the first reset cycle.
  assign rsp_valid = rst ? '0 : tail_valid;
  assign rsp_rdata = sram_dout;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_sram_arbiter;

  localparam int NR = 3;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int AW = 14;
`ifdef SRAM_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NR*MW-1:0] req_wem;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, sram_din, sram_dout;
  logic             sram_cs, sram_we;
  logic [MW-1:0]    sram_wem;
  logic [AW-1:0]    sram_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.NR(NR), .DW(DW), .MW(MW), .AW(AW), .RL(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wem(req_wem), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_wem(sram_wem),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [DW-1:0] sram_mem [int];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we)
        sram_mem[int'(sram_addr)] = merge(sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : '0,
                                          sram_din, sram_wem);
      else
        sram_dout <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : '0;
    end
  end

  // Reference model state.
  typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  logic [DW-1:0] shadow [int];
  int            cyc = 0;
  int            mptr = 0;
  int            exp_idx;
  logic [NR-1:0] exp_ready, exp_rsp_valid;
  logic [DW-1:0] exp_rsp_data;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;
  bit            have_last = 0;

  function automatic logic [DW-1:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [MW-1:0] wem,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid[i]           = 1'b1;
    req_we[i]              = we;
    req_wem[i*MW +: MW]    = wem;
    req_addr[i*AW +: AW]   = addr;
    req_wdata[i*DW +: DW]  = data;
  endtask

  // Let combinational outputs settle, then derive this cycle's expectations.
  task automatic settle();
    #1;
    if (rst) while (rq.size() > 0 && rq[rq.size()-1].due >= cyc + LAT - 1) void'(rq.pop_back());
    exp_ready = '0;
    exp_idx   = -1;
    if (!rst)
      for (int k = 0; k < NR; k++)
        if (exp_idx < 0 && req_valid[(mptr + k) % NR]) begin
          exp_idx = (mptr + k) % NR;
          exp_ready[exp_idx] = 1'b1;
        end
    exp_rsp_valid = '0;
    exp_rsp_data  = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rsp_valid[rq[0].id] = 1'b1;
      exp_rsp_data = rq[0].data;
    end
  endtask

  // Commit the model for this cycle and move to the next sampling point.
  task automatic advance();
    int a;
    if (exp_idx >= 0) begin
      a = int'(req_addr[exp_idx*AW +: AW]);
      if (req_we[exp_idx]) shadow[a] = merge(shadow_rd(a), req_wdata[exp_idx*DW +: DW], req_wem[exp_idx*MW +: MW]);
      else rq.push_back('{cyc + LAT, exp_idx, shadow_rd(a)});
      last_addr = req_addr[exp_idx*AW +: AW];
      last_din  = req_wdata[exp_idx*DW +: DW];
      have_last = 1;
      mptr = (exp_idx + 1) % NR;
    end
    if (rst) begin
      mptr = 0;
      have_last = 0;
    end
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin settle(); advance(); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (2) begin
      settle();
      n_vec++;
      if (req_ready !== '0 || sram_cs !== 1'b0 || sram_we !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs: ready=%b cs=%b we=%b want 000/0/0", req_ready, sram_cs, sram_we);
      end
      advance();
    end
    rst = 1'b0;
    idle();
    repeat (10) begin
      settle();
      n_vec++;
      if (req_ready !== '0 || sram_cs !== 1'b0 || rsp_valid !== '0) begin
        n_err++;
        $display("FAIL post_reset_idle: ready=%b cs=%b rsp=%b want 000/0/000", req_ready, sram_cs, rsp_valid);
      end
      advance();
    end
    req_valid = '1;
    settle();
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL reset_ptr: ready=%b want 001", req_ready);
    end
    advance();
    idle();
  endtask

  task automatic test_write_read();
    do_reset(1);
    idle();
    set_req(1, 1'b1, 8'hFF, 14'h0010, 64'h1122334455667788);
    settle();
    n_vec++;
    if (req_ready !== 3'b010 || sram_cs !== 1'b1 || sram_we !== 1'b1 ||
        sram_addr !== 14'h0010 || sram_din !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL write_pins: ready=%b cs=%b we=%b addr=%h din=%h want 010/1/1/0010/1122334455667788",
               req_ready, sram_cs, sram_we, sram_addr, sram_din);
    end
    advance();
    idle();
    settle();
    n_vec++;
    if (sram_cs !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 14'h0010) begin
      n_err++;
      $display("FAIL idle_hold: cs=%b we=%b addr=%h want 0/0/0010", sram_cs, sram_we, sram_addr);
    end
    advance();
    set_req(1, 1'b0, 8'h00, 14'h0010, 64'h0);
    settle();
    n_vec++;
    if (req_ready !== 3'b010 || sram_we !== 1'b0) begin
      n_err++;
      $display("FAIL read_grant: ready=%b we=%b want 010/0", req_ready, sram_we);
    end
    advance();
    idle();
    for (int s = 1; s <= LAT + 1; s++) begin
      settle();
      n_vec++;
      if (s == LAT) begin
        if (rsp_valid !== 3'b010 || rsp_rdata !== 64'h1122334455667788) begin
          n_err++;
          $display("FAIL read_rsp: rsp=%b data=%h want 010/1122334455667788", rsp_valid, rsp_rdata);
        end
      end else if (rsp_valid !== 3'b000) begin
        n_err++;
        $display("FAIL read_rsp_timing(s=%0d): rsp=%b want 000", s, rsp_valid);
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    do_reset(1);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'hFF, AW'(14'h0100 + i), {$urandom, $urandom});
    for (int k = 0; k < 9; k++) begin
      settle();
      n_vec++;
      if (req_ready !== NR'(1 << (k % NR))) begin
        n_err++;
        $display("FAIL round_robin[%0d]: ready=%b want %b", k, req_ready, NR'(1 << (k % NR)));
      end
      advance();
    end
    idle();
  endtask

  task automatic test_partial_write();
    idle();
    set_req(2, 1'b1, 8'hFF, 14'h0020, 64'h0);
    settle(); advance();
    set_req(2, 1'b1, 8'h0F, 14'h0020, 64'hAAAAAAAA_BBBBBBBB);
    settle(); advance();
    set_req(2, 1'b0, 8'h00, 14'h0020, 64'h0);
    settle(); advance();
    idle();
    repeat (LAT - 1) begin settle(); advance(); end
    settle();
    n_vec++;
    if (rsp_valid !== 3'b100 || rsp_rdata !== 64'h00000000_BBBBBBBB) begin
      n_err++;
      $display("FAIL partial_write: rsp=%b data=%h want 100/00000000bbbbbbbb", rsp_valid, rsp_rdata);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    idle();
    set_req(0, 1'b1, 8'hFF, 14'h0001, 64'h1);
    settle(); advance();
    set_req(0, 1'b1, 8'hFF, 14'h0002, 64'h2);
    settle(); advance();
    for (int s = 0; s <= LAT + 2; s++) begin
      idle();
      if (s == 0) set_req(0, 1'b0, 8'h00, 14'h0001, 64'h0);
      if (s == 1) set_req(2, 1'b0, 8'h00, 14'h0002, 64'h0);
      settle();
      n_vec++;
      if (s == LAT) begin
        if (rsp_valid !== 3'b001 || rsp_rdata !== 64'h1) begin
          n_err++;
          $display("FAIL b2b_first: rsp=%b data=%h want 001/1", rsp_valid, rsp_rdata);
        end
      end else if (s == LAT + 1) begin
        if (rsp_valid !== 3'b100 || rsp_rdata !== 64'h2) begin
          n_err++;
          $display("FAIL b2b_second: rsp=%b data=%h want 100/2", rsp_valid, rsp_rdata);
        end
      end else if (rsp_valid !== 3'b000) begin
        n_err++;
        $display("FAIL b2b_quiet(s=%0d): rsp=%b want 000", s, rsp_valid);
      end
      advance();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s <= 5; s++) begin
      idle();
      rst = (s == 1 || s == 2);
      if (s == 0) set_req(0, 1'b0, 8'h00, 14'h0001, 64'h0);
      if (s == 5) for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'hFF, AW'(14'h0200 + i), 64'h5);
      settle();
      n_vec++;
      if (s == 0 && req_ready !== 3'b001) begin
        n_err++;
        $display("FAIL reset_mid_grant: ready=%b want 001", req_ready);
      end else if (s >= 1 && s <= 4 && rsp_valid !== 3'b000) begin
        n_err++;
        $display("FAIL reset_mid_drop(s=%0d): rsp=%b want 000", s, rsp_valid);
      end else if (s == 5 && req_ready !== 3'b001) begin
        n_err++;
        $display("FAIL reset_mid_ptr: ready=%b want 001", req_ready);
      end
      advance();
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_random();
    logic [NR-1:0] acc;
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? MW'($urandom) : 8'hFF,
                  AW'($urandom_range(0, 15)), {$urandom, $urandom});
      rst = ($urandom_range(0, 59) == 0);
      settle();
      n_vec++;
      if (req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, exp_ready);
      end
      n_vec++;
      if (sram_cs !== (exp_idx >= 0)) begin
        n_err++;
        $display("FAIL rnd_cs@%0d: got %b want %b", cyc, sram_cs, exp_idx >= 0);
      end
      if (exp_idx >= 0) begin
        n_vec++;
        if (sram_we !== req_we[exp_idx] || sram_addr !== req_addr[exp_idx*AW +: AW] ||
            sram_wem !== req_wem[exp_idx*MW +: MW] || sram_din !== req_wdata[exp_idx*DW +: DW]) begin
          n_err++;
          $display("FAIL rnd_mux@%0d: we=%b addr=%h wem=%h din=%h want requester %0d fields",
                   cyc, sram_we, sram_addr, sram_wem, sram_din, exp_idx);
        end
      end else begin
        n_vec++;
        if (sram_we !== 1'b0 || (have_last && (sram_addr !== last_addr || sram_din !== last_din))) begin
          n_err++;
          $display("FAIL rnd_hold@%0d: we=%b addr=%h din=%h want 0/%h/%h",
                   cyc, sram_we, sram_addr, sram_din, last_addr, last_din);
        end
      end
      n_vec++;
      if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid != '0 && rsp_rdata !== exp_rsp_data)) begin
        n_err++;
        $display("FAIL rnd_rsp@%0d: rsp=%b data=%h want %b/%h", cyc, rsp_valid, rsp_rdata,
                 exp_rsp_valid, exp_rsp_data);
      end
      acc = exp_ready;
      advance();
      req_valid = req_valid & ~acc;
    end
    rst = 1'b0;
    idle();
    repeat (LAT + 1) begin settle(); advance(); end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_wem   = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_round_robin();
    test_partial_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
